vector_vwrite: RTL and testbench

Write-side counterpart of the byte field-splitting path: accepts the split field set (1-bit `res1`, 4-bit `res2`, 8-bit `res3[0:7]`) and reassembles the original 8-bit `data` byte. Each accepted set is checked for field consistency. Consistent bytes are buffered in a small first-word-fall-through FIFO and presented on a valid/ready output; inconsistent sets are dropped and counted. It sits between any field producer and the byte consumer that originally fed the splitter.

---
 rtl/vector_vwrite.sv | 125 ++++++++++++
 tb/tb_vector_vwrite.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_vwrite.sv
// -----------------------------------------------------------------------------
// vector_vwrite
//
// Write-side partner of the byte field splitter. A field set {res1, res2, res3}
// is reassembled into a byte and checked for consistency. Consistent bytes go
// into a first-word-fall-through FIFO and leave on a valid/ready port.
// Inconsistent sets are consumed, dropped and counted.
//
// Parameters:
//   DEPTH      FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   field set on res1/res2/res3 is valid
//   in_ready   block can take a field set this cycle
//   res1       copy of data[7]
//   res2       copy of data[3:0]
//   res3       full byte, MSB-indexed (res3[i] = data[7-i])
//   out_valid  data holds the FIFO head
//   out_ready  consumer takes the head this cycle
//   data       FIFO head, 8'h00 when empty
//   err        one-cycle pulse after a rejected set
//   err_count  saturating count of rejected sets
//   level      current FIFO occupancy
// -----------------------------------------------------------------------------
module vector_vwrite #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       res1,
  input  logic [3:0]                 res2,
  input  logic [0:7]                 res3,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 data,
  output logic                       err,
  output logic [7:0]                 err_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_q, err_d;
  logic [7:0]    err_count_q, err_count_d;

  logic [7:0]    byte_w;
  logic          good_w;
  logic          accept_w;
  logic          push_w;
  logic          pop_w;

  // res3 is declared [0:7], so a packed copy puts res3[0] on bit 7, which is
  // exactly byte[7-i] = res3[i].
  assign byte_w = res3;
  assign good_w = (res1 == byte_w[7]) && (res2 == byte_w[3:0]);

  // Ready comes only from registered occupancy and rst; out_ready never feeds
  // it, so a full FIFO does not accept even when it is being popped.
  assign in_ready  = !rst && (level_q != LW'(DEPTH));
  assign out_valid = !rst && (level_q != '0);
  assign data      = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign level     = level_q;

  assign accept_w = in_valid && in_ready;
  assign push_w   = accept_w && good_w;
  assign pop_w    = out_valid && out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    err_d       = accept_w && !good_w;
    err_count_d = err_count_q;

    if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;  // wraps naturally, DEPTH = 2**AW
    if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push_w, pop_w})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (accept_w && !good_w && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: storage is not reset; level gates data to 8'h00 when empty, so
  // stale contents are never visible and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= byte_w;
  end

endmodule

// File: tb/tb_vector_vwrite.sv
// -----------------------------------------------------------------------------
// tb_vector_vwrite
//
// Drives directed scenarios then constrained-random traffic into vector_vwrite.
// A queue-based reference model advances at every rising edge; a single
// falling-edge process compares all outputs against it. Directed scenarios
// also carry literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_vector_vwrite;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          res1;
  logic [3:0]    res2;
  logic [0:7]    res3;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    data;
  logic          err;
  logic [7:0]    err_count;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  vector_vwrite #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res1      (res1),
    .res2      (res2),
    .res3      (res3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data      (data),
    .err       (err),
    .err_count (err_count),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  bit         m_err = 1'b0;
  int         m_cnt = 0;

  always @(posedge clk) begin
    bit         ready, ov, acc, good;
    logic [7:0] b;
    if (rst) begin
      m_q.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      ready = (m_q.size() != DEPTH);
      ov    = (m_q.size() != 0);
      acc   = in_valid && ready;
      for (int i = 0; i < 8; i++) b[7-i] = res3[i];
      good  = (res1 == b[7]) && (res2 == b[3:0]);
      if (ov && out_ready) void'(m_q.pop_front());
      if (acc && good) m_q.push_back(b);
      m_err = acc && !good;
      if (acc && !good && m_cnt < 255) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit         e_ready, e_ov;
      logic [7:0] e_data;
      e_ready = !rst && (m_q.size() != DEPTH);
      e_ov    = !rst && (m_q.size() != 0);
      e_data  = e_ov ? m_q[0] : 8'h00;
      check("model_in_ready",  int'(in_ready),  int'(e_ready));
      check("model_out_valid", int'(out_valid), int'(e_ov));
      check("model_data",      int'(data),      int'(e_data));
      check("model_level",     int'(level),     m_q.size());
      check("model_err",       int'(err),       int'(m_err));
      check("model_err_count", int'(err_count), m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [7:0] b, input bit good);
    res3 = b;                       // res3[0] takes b[7]
    res1 = good ? b[7] : ~b[7];
    res2 = b[3:0];
  endtask

  initial begin
    int n_out;
    bit pending;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    res1 = 1'b0; res2 = 4'h0; res3 = 8'h00;

    // Reset then idle
    step(); step();
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_data",      int'(data),      8'h00);
    check("rst_err_count", int'(err_count), 0);
    check("rst_level",     int'(level),     0);

    // Single good set A5
    step();
    res3 = 8'b1010_0101; res1 = 1'b1; res2 = 4'h5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("a5_out_valid", int'(out_valid), 1);
    check("a5_data",      int'(data),      8'hA5);
    check("a5_level",     int'(level),     1);
    check("a5_err",       int'(err),       0);

    // Bad set: byte 3C with res1 = 1
    step();
    res3 = 8'h3C; res1 = 1'b1; res2 = 4'hC; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bad_err",       int'(err),       1);
    check("bad_err_count", int'(err_count), 1);
    check("bad_level",     int'(level),     1);
    step();
    @(negedge clk);
    check("bad_err_one_cycle", int'(err), 0);

    // 300 more bad sets saturate the counter
    step();
    set_fields(8'h3C, 1'b0);
    in_valid = 1'b1;
    repeat (300) step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check("sat_err_count", int'(err_count), 255);
    check("sat_level",     int'(level),     1);

    // Drain A5
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Fill with 01..04
    for (int k = 1; k <= 4; k++) begin
      set_fields(8'(k), 1'b1);
      in_valid = 1'b1;
      step();
    end
    set_fields(8'h05, 1'b1);     // fifth set held while full
    repeat (3) step();
    @(negedge clk);
    check("full_level",    int'(level),    4);
    check("full_in_ready", int'(in_ready), 0);
    check("full_head",     int'(data),     8'h01);
    out_ready = 1'b1;            // pop 01; 05 still blocked at this edge
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("after_pop_in_ready", int'(in_ready), 1);
    check("after_pop_level",    int'(level),    3);
    @(posedge clk); #1;          // 05 accepted here
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("fill_pop_order", int'(data), k);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("fill_drained", int'(level), 0);

    // Streaming with wrap: 10..19
    n_out = 0;
    step();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k < 10) set_fields(8'h10 + 8'(k), 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      check("stream_level_le1", int'(level <= 1), 1);
      if (out_valid) begin
        check("stream_order", int'(data), 8'h10 + n_out);
        n_out++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("stream_count", n_out, 10);

    // Reset mid-stream at level 3
    for (int k = 0; k < 3; k++) begin
      set_fields(8'hE0 + 8'(k), 1'b1);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_level3", int'(level), 3);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_level",     int'(level),     0);
    @(posedge clk); #1;
    set_fields(8'h77, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_first_valid", int'(out_valid), 1);
    check("mid_first_data",  int'(data),      8'h77);

    // Constrained-random traffic; a set is held until accepted
    @(posedge clk); #1;
    pending = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_fields(8'($urandom), $urandom_range(0, 5) != 0);
        pending = in_valid;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      if (in_valid && in_ready) pending = 1'b0;
      if (rst) pending = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    step(); step();

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
